// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button encoder.
package btn_pkg;

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  localparam int         DEBOUNCE_DEFAULT = 50000;
  localparam logic [3:0] BTN_RELEASED     = 4'b1111;

  // Lowest pressed (low) index wins.
  function automatic logic [1:0] btn_encode(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    casez (v)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // More than one pressed bit: clearing the lowest set bit of ~v leaves something.
  function automatic logic btn_multi(input logic [3:0] v);
    logic [3:0] p;
    p = ~v;
    return (p & (p - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// 2-flop synchronizer followed by a whole-vector stability counter.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    meta, sync, cand;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= BTN_RELEASED;
      sync <= BTN_RELEASED;
      cand <= BTN_RELEASED;
      dout <= BTN_RELEASED;
      cnt  <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      // Any change restarts the window; only a full quiet window promotes cand.
      if (sync != cand) begin
        cand <= sync;
        cnt  <= '0;
      end else if (cnt == CMAX) begin
        dout <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_encoder.sv
// Debounced 4-button priority encoder with one-shot press pulse.
module btn_encoder
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_n,
  output logic [1:0] code,
  output logic       valid,
  output logic       pressed,
  output logic       multi
);

  logic [3:0] deb;
  state_t     state;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (btn_n),
    .dout (deb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      code  <= 2'd0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      valid <= 1'b0;
      multi <= btn_multi(deb);
      case (state)
        IDLE: if (deb != BTN_RELEASED) begin
          state <= HELD;
          code  <= btn_encode(deb);
          valid <= 1'b1;
        end
        // Extra presses or partial releases are ignored until all-up.
        HELD: if (deb == BTN_RELEASED) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pressed = (state == HELD);

endmodule

// File: tb/tb_btn_encoder.sv
// Self-checking bench for btn_encoder with DEBOUNCE_CYCLES=4.
module tb_btn_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_n = 4'hF;
  logic [1:0] code;
  logic       valid, pressed, multi;

  btn_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n  (btn_n),
    .code   (code),
    .valid  (valid),
    .pressed(pressed),
    .multi  (multi)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: debounced value = input sample stable across D+1
  // consecutive synchronized samples; outputs derived from the previous
  // debounced value.
  logic [3:0] smp[$];
  logic [3:0] m_deb;
  logic       m_pressed, m_valid, m_multi;
  logic [1:0] m_code;

  // Scenario bookkeeping.
  int         vcnt, first_v, idx;
  logic [1:0] vcode;
  logic       p_seen;

  typedef struct {
    logic [3:0] btn;
    int         n;
    int         exp_v;
    logic [1:0] exp_code;
    logic       exp_p;
    logic       exp_m;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [1:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    smp.delete();
    repeat (D + 2) smp.push_back(4'hF);
    m_deb = 4'hF; m_pressed = 1'b0; m_valid = 1'b0; m_code = 2'd0; m_multi = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] s);
    logic [3:0] prev;
    logic       was, stable;
    prev      = m_deb;
    was       = m_pressed;
    m_pressed = (prev != 4'hF);
    m_valid   = m_pressed && !was;
    if (m_valid) m_code = lowest(prev);
    m_multi   = ($countones(~prev) > 1);
    stable = 1'b1;
    for (int i = 0; i < D; i++) if (smp[i] != smp[D]) stable = 1'b0;
    if (stable) m_deb = smp[D];
    smp.push_back(s);
    void'(smp.pop_front());
  endtask

  // One clock: drive, let the edge happen, then compare everything.
  task automatic cyc(input logic [3:0] b);
    btn_n = b;
    @(posedge clk);
    model_edge(btn_n);
    #1;
    chk("cycle {code,valid,pressed,multi}", int'({code, valid, pressed, multi}),
        int'({m_code, m_valid, m_pressed, m_multi}));
    idx++;
    if (pressed) p_seen = 1'b1;
    if (valid) begin
      vcnt++;
      vcode = code;
      if (first_v < 0) first_v = idx;
    end
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) cyc(b);
  endtask

  task automatic clr();
    vcnt = 0; first_v = -1; idx = 0; p_seen = 1'b0; vcode = 2'd0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    chk("reset outputs", int'({code, valid, pressed, multi}), 0);
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    chk("reset outputs held", int'({code, valid, pressed, multi}), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{4'hE, 10, 1, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{4'hF, 10, 0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{4'hD, 10, 1, 2'd1, 1'b1, 1'b0};
    tbl[3]  = '{4'hF, 10, 0, 2'd1, 1'b0, 1'b0};
    tbl[4]  = '{4'hB, 10, 1, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{4'hF, 10, 0, 2'd2, 1'b0, 1'b0};
    tbl[6]  = '{4'h7, 10, 1, 2'd3, 1'b1, 1'b0};
    tbl[7]  = '{4'hF, 10, 0, 2'd3, 1'b0, 1'b0};
    tbl[8]  = '{4'h9, 10, 1, 2'd1, 1'b1, 1'b1};
    tbl[9]  = '{4'h0, 10, 0, 2'd1, 1'b1, 1'b1};
    tbl[10] = '{4'hC,  3, 0, 2'd1, 1'b1, 1'b1};
    tbl[11] = '{4'hF, 10, 0, 2'd1, 1'b0, 1'b0};

    model_reset();
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("power-on reset outputs", int'({code, valid, pressed, multi}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean press: valid at edge D+4, release drops pressed D+4 edges later.
    clr();
    hold(4'hB, 12);
    chk("press latency", first_v, D + 4);
    chk("press valid count", vcnt, 1);
    chk("press code", int'(vcode), 2);
    chk("press pressed", int'(pressed), 1);
    clr();
    first_v = -1;
    for (int i = 1; i <= 12; i++) begin
      cyc(4'hF);
      if (!pressed && first_v < 0) first_v = i;
    end
    chk("release latency", first_v, D + 4);
    chk("release no valid", vcnt, 0);

    // Bounce then settle.
    clr();
    for (int i = 0; i < 20; i++) cyc(((i / 2) % 2) != 0 ? 4'hE : 4'hF);
    hold(4'hE, 12);
    chk("bounce valid count", vcnt, 1);
    chk("bounce code", int'(vcode), 0);
    hold(4'hF, 12);

    // Short glitch is rejected.
    clr();
    hold(4'h7, 3);
    hold(4'hF, 12);
    chk("glitch valid count", vcnt, 0);
    chk("glitch pressed seen", int'(p_seen), 0);

    // Two buttons at once, then partial release.
    clr();
    hold(4'h5, 12);
    chk("multi valid count", vcnt, 1);
    chk("multi code", int'(vcode), 1);
    chk("multi flag", int'(multi), 1);
    clr();
    hold(4'h7, 12);
    chk("partial release no valid", vcnt, 0);
    chk("partial release code", int'(code), 1);
    chk("partial release multi", int'(multi), 0);
    hold(4'hF, 12);

    // Held through reset: counts as a fresh press afterwards.
    hold(4'hD, 12);
    chk("held before reset", int'(pressed), 1);
    do_reset(2);
    clr();
    hold(4'hD, 12);
    chk("post-reset latency", first_v, D + 4);
    chk("post-reset code", int'(vcode), 1);

    // Re-press after full release.
    hold(4'hF, 12);
    chk("re-press released", int'(pressed), 0);
    clr();
    hold(4'hE, 12);
    chk("re-press valid count", vcnt, 1);
    chk("re-press code", int'(vcode), 0);
    hold(4'hF, 12);

    // Table of settled vectors.
    for (int i = 0; i < 12; i++) begin
      clr();
      hold(tbl[i].btn, tbl[i].n);
      chk($sformatf("tbl[%0d] valid count", i), vcnt, tbl[i].exp_v);
      chk($sformatf("tbl[%0d] code", i), int'(code), int'(tbl[i].exp_code));
      chk($sformatf("tbl[%0d] pressed", i), int'(pressed), int'(tbl[i].exp_p));
      chk($sformatf("tbl[%0d] multi", i), int'(multi), int'(tbl[i].exp_m));
    end

    // Random bursts checked cycle by cycle against the model.
    for (int k = 0; k < 80; k++) begin
      logic [3:0] b;
      b = 4'($urandom);
      if ($urandom_range(0, 2) == 0) b = 4'hF;
      if ($urandom_range(0, 14) == 0) do_reset(int'($urandom_range(1, 3)));
      hold(b, int'($urandom_range(1, 9)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
